pri_enc_drain: RTL and testbench

//   Parametrised N-input sequential priority encoder. Captures a request vector and

---
 rtl/pri_enc_pkg.sv | 26 ++
 rtl/pri_enc_ffs.sv | 33 +++
 rtl/pri_enc_drain.sv | 116 +++++++++++
 tb/tb_pri_enc_drain.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pri_enc_pkg.sv
// Shared types and helpers for the sequential priority encoder (pri_enc_drain).
// Round-robin priority is enabled by defining PRI_ENC_RR_EN.
package pri_enc_pkg;

    localparam int MAX_N = 256;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_e;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_N; i++) begin
            c = c + {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pri_enc_ffs.sv
// Combinational find-first-set over an N-bit vector, scanning upward from start_i
// and wrapping N-1 -> 0.
module pri_enc_ffs
    import pri_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int pos;
        idx_o   = '0;
        found_o = 1'b0;
        pos     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = int'(start_i) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (vec_i[pos]) begin
                idx_o   = W'(pos);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pri_enc_drain.sv
// Sequential priority encoder: captures a request vector and hands out one set
// index per handshake. Define PRI_ENC_RR_EN for round-robin instead of LSB-first.
module pri_enc_drain
    import pri_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [N-1:0] a_i,
    input  logic         a_valid_i,
    output logic         a_ready_o,
    output logic [W-1:0] y_o,
    output logic         y_valid_o,
    input  logic         y_ready_i,
    output logic [W:0]   cnt_o,
    output logic         none_o
);

    state_e       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W:0]   cnt_q, cnt_d;
    logic         none_q, none_d;
    logic [W-1:0] scanStart;
    logic [W-1:0] ffsIdx;
    logic         ffsFound;
    logic         pop;

`ifdef PRI_ENC_RR_EN
    logic [W-1:0] ptr_q, ptr_d;

    assign scanStart = ptr_q;

    // The pointer survives across vectors so service rotates fairly.
    always_comb begin
        ptr_d = ptr_q;
        if (pop) begin
            ptr_d = (ffsIdx == W'(N - 1)) ? '0 : ffsIdx + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign scanStart = '0;
`endif

    pri_enc_ffs #(.N(N)) u_ffs (
        .vec_i   (pend_q),
        .start_i (scanStart),
        .idx_o   (ffsIdx),
        .found_o (ffsFound)
    );

    assign y_o    = ffsIdx;
    assign cnt_o  = cnt_q;
    assign none_o = none_q;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        none_d    = 1'b0;
        a_ready_o = 1'b0;
        y_valid_o = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                a_ready_o = en_i;
                if (en_i && a_valid_i) begin
                    if (a_i != '0) begin
                        pend_d  = a_i;
                        cnt_d   = (W + 1)'(popcount(MAX_N'(a_i)));
                        state_d = DRAIN;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                y_valid_o = en_i && ffsFound;
                if (y_valid_o && y_ready_i) begin
                    pop            = 1'b1;
                    pend_d[ffsIdx] = 1'b0;
                    cnt_d          = cnt_q - (W + 1)'(1);
                    if (cnt_q == (W + 1)'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            none_q  <= none_d;
        end
    end

endmodule

// File: tb/tb_pri_enc_drain.sv
// Self-checking bench for pri_enc_drain: a set-of-pending-bits model checked every
// cycle plus directed literal expectations. Honours PRI_ENC_RR_EN.
module tb_pri_enc_drain;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] a;
    logic         aValid;
    logic         aReady;
    logic [W-1:0] y;
    logic         yValid;
    logic         yReady;
    logic [W:0]   cnt;
    logic         none;

    int checks   = 0;
    int failures = 0;
    bit checkOn  = 1'b0;

    pri_enc_drain #(.N(N)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .a_i       (a),
        .a_valid_i (aValid),
        .a_ready_o (aReady),
        .y_o       (y),
        .y_valid_o (yValid),
        .y_ready_i (yReady),
        .cnt_o     (cnt),
        .none_o    (none)
    );

    always #5 clk = ~clk;

    // Model: idle flag, set of pending request bits, rotation start and the none strobe.
    bit           mIdle = 1'b1;
    bit [N-1:0]   mPend = '0;
    int           mPtr  = 0;
    bit           mNone = 1'b0;

    function automatic int nextServed(bit [N-1:0] v, int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    function automatic int bitsSet(bit [N-1:0] v);
        int c = 0;
        for (int k = 0; k < N; k++) c += int'(v[k]);
        return c;
    endfunction

    function automatic int scanFrom();
`ifdef PRI_ENC_RR_EN
        return mPtr;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        int served;
        if (rst) begin
            mIdle = 1'b1;
            mPend = '0;
            mPtr  = 0;
            mNone = 1'b0;
        end else begin
            mNone = 1'b0;
            if (mIdle && en && aValid) begin
                if (a != '0) begin
                    mPend = a;
                    mIdle = 1'b0;
                end else begin
                    mNone = 1'b1;
                end
            end else if (!mIdle && en && yReady) begin
                served        = nextServed(mPend, scanFrom());
                mPend[served] = 1'b0;
                mPtr          = (served + 1) % N;
                if (mPend == '0) mIdle = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Every cycle, mid-period, compare all outputs with the model.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("model a_ready", int'(aReady), int'(mIdle && en));
            checkOutput("model y_valid", int'(yValid), int'(!mIdle && en));
            checkOutput("model y", int'(y), nextServed(mPend, scanFrom()));
            checkOutput("model cnt", int'(cnt), bitsSet(mPend));
            checkOutput("model none", int'(none), int'(mNone));
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    task automatic drainAll(input string name, input int e0, input int e1);
        #1 checkOutput({name, " first y"}, int'(y), e0);
        applyStimulus();
        #1 checkOutput({name, " second y"}, int'(y), e1);
        applyStimulus();
        #1 checkOutput({name, " back to idle"}, int'(aReady), 1);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        a      = '0;
        aValid = 1'b0;
        yReady = 1'b0;
        applyStimulus();
        checkOn = 1'b1;
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("reset y_valid", int'(yValid), 0);
        checkOutput("reset y", int'(y), 0);
        checkOutput("reset cnt", int'(cnt), 0);
        checkOutput("reset none", int'(none), 0);
        checkOutput("reset a_ready", int'(aReady), 1);

        // Free-flowing drain of 1001_0010.
        a = 8'h92; aValid = 1'b1; yReady = 1'b1;
        applyStimulus();
        aValid = 1'b0;
        #1 checkOutput("drain y0", int'(y), 1);
        checkOutput("drain cnt0", int'(cnt), 3);
        checkOutput("drain a_ready low", int'(aReady), 0);
        applyStimulus();
        #1 checkOutput("drain y1", int'(y), 4);
        checkOutput("drain cnt1", int'(cnt), 2);
        applyStimulus();
        #1 checkOutput("drain y2", int'(y), 7);
        checkOutput("drain cnt2", int'(cnt), 1);
        applyStimulus();
        #1 checkOutput("drain a_ready after last", int'(aReady), 1);
        checkOutput("drain cnt empty", int'(cnt), 0);

        // Backpressure holds y and cnt.
        a = 8'h92; aValid = 1'b1; yReady = 1'b0;
        applyStimulus();
        aValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            #1 checkOutput("stall y", int'(y), 1);
            checkOutput("stall cnt", int'(cnt), 3);
        end
        yReady = 1'b1;
        applyStimulus();
        #1 checkOutput("release y", int'(y), 4);
        checkOutput("release cnt", int'(cnt), 2);
        applyStimulus();
        applyStimulus();

        // All-zero vector produces a single none pulse.
        a = 8'h00; aValid = 1'b1;
        applyStimulus();
        aValid = 1'b0;
        #1 checkOutput("zero none", int'(none), 1);
        checkOutput("zero y_valid", int'(yValid), 0);
        applyStimulus();
        #1 checkOutput("zero none cleared", int'(none), 0);
        checkOutput("zero still idle", int'(aReady), 1);

        // Enable freeze mid-drain, then reset while bits are pending.
        a = 8'h92; aValid = 1'b1; yReady = 1'b1;
        applyStimulus();
        aValid = 1'b0;
        applyStimulus();
        en = 1'b0;
        #1 checkOutput("freeze y_valid", int'(yValid), 0);
        checkOutput("freeze cnt", int'(cnt), 2);
        applyStimulus();
        applyStimulus();
        #1 checkOutput("frozen cnt", int'(cnt), 2);
        en = 1'b1; yReady = 1'b0;
        #1 checkOutput("resume y", int'(y), 4);
        checkOutput("resume y_valid", int'(yValid), 1);
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        #1 checkOutput("mid-drain reset cnt", int'(cnt), 0);
        checkOutput("mid-drain reset y_valid", int'(yValid), 0);
        checkOutput("mid-drain reset a_ready", int'(aReady), 1);

        // Priority order across two consecutive vectors.
        yReady = 1'b1;
        a = 8'h05; aValid = 1'b1;
        applyStimulus();
        aValid = 1'b0;
        drainAll("vec 05", 0, 2);
        a = 8'h09; aValid = 1'b1;
        applyStimulus();
        aValid = 1'b0;
`ifdef PRI_ENC_RR_EN
        drainAll("vec 09 rr", 3, 0);
`else
        drainAll("vec 09 fixed", 0, 3);
`endif

        applyStimulus();
        applyStimulus();
        checkOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
